quad_encoder_gen: RTL

- Quadrature encoder emulator: drives A/B 2-bit Gray-code signals that the debounce and decoder chain consumes.
- Used for closed-loop self-test and bench stimulus of the encoder input path.
- Accepts a step-count/direction command with start/busy/done handshake.
- Emits one quadrature phase transition every DWELL clocks until the count is exhausted or the command is aborted.

---
 rtl/quad_encoder_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/quad_encoder_gen.sv
// Purpose: quadrature A/B emulator that emits N Gray-code phase steps, one every DWELL clocks.
// Latency: start sampled in cycle T; step k appears at T+1+k*DWELL; done pulses with the last step.
// Backpressure: none; start is ignored while busy, and abort ends a run early with a/b held.
module quad_encoder_gen #(
  parameter int unsigned DWELL  = 334,
  parameter int unsigned BITS   = 9,
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  input  logic              abort,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] remaining
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [BITS-1:0]   CNT_LAST = BITS'(DWELL - 1);
  localparam logic [STEP_W-1:0] REM_ONE  = STEP_W'(1);

  state_t            state_q, state_d;
  logic [BITS-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              dir_q, dir_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              done_q, done_d;

  // Next-state: command capture in IDLE, dwell counting and phase stepping in RUN.
  // The phase is kept directly as the (a,b) pair so both outputs come straight off flops.
  // Forward walks 00->10->11->01 (a'=~b, b'=a); reverse walks the opposite way (a'=b, b'=~a).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        rem_d = '0;
        if (start) begin
          dir_d = dir;
          if (steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = steps;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort beats a coinciding final step: phase is held and no done pulse.
          state_d = S_IDLE;
          cnt_d   = '0;
          rem_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          rem_d = rem_q - REM_ONE;
          if (dir_q) begin
            a_d = ~b_q;
            b_d = a_q;
          end else begin
            a_d = b_q;
            b_d = ~a_q;
          end
          if (rem_q == REM_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset that overrides any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign remaining = rem_q;

endmodule
